video_hsync_lock: RTL and testbench

Horizontal sync receiver and flywheel for the video path. It samples an incoming active-high hsync level on the 7 MHz `cend` strobe and measures the line period and sync width. Once the input has shown a stable 448-cycle line, it locks a free-running recovered horizontal counter to that input. Downstream logic (scan-doubler, external-sync overlay) uses it in place of the local horizontal sync generator's counter when following an external or looped-back sync source.

---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/video_hsync_meas.sv | 79 +++++++
 rtl/video_hsync_lock.sv | 156 +++++++++++++++
 tb/tb_video_hsync_lock.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared horizontal timing constants and lock-state encoding.
// Used by the sync generator and the hsync flywheel.
package video_timing_pkg;

  localparam logic [8:0] HPERIOD   = 9'd448;
  localparam logic [8:0] HSYNC_BEG = 9'd10;
  localparam logic [8:0] HSYNC_END = 9'd43;
  localparam logic [8:0] HBLNK_END = 9'd88;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } hs_state_e;

  // Circular distance between two positions on a line of length per.
  function automatic logic [8:0] hdist(
    input logic [8:0] a,
    input logic [8:0] b,
    input logic [8:0] per
  );
    logic [8:0] d;
    d = (a >= b) ? a - b : b - a;
    return (d > per - d) ? per - d : d;
  endfunction

endpackage

// File: rtl/video_hsync_meas.sv
// Hsync edge detector with period and sync-width measurement.
// Period and width saturate instead of wrapping.
module video_hsync_meas #(
  parameter logic [8:0] HPERIOD = 9'd448,
  parameter logic [3:0] TOL     = 4'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cend,
  input  logic       hsync_in,
  output logic       edge_det,
  output logic [8:0] period_new,
  output logic       good,
  output logic       timeout,
  output logic [8:0] period,
  output logic [5:0] sync_len
);

  logic       hs_q, hs_d;
  logic       fall;
  logic [8:0] per_q, per_d;
  logic [8:0] period_q, period_d;
  logic [8:0] dev;
  logic [5:0] len_q, len_d;
  logic [5:0] slen_q, slen_d;

  assign edge_det   = cend & hsync_in & ~hs_q;
  assign fall       = cend & ~hsync_in & hs_q;
  assign timeout    = &per_q;
  assign period_new = timeout ? per_q : per_q + 9'd1;
  assign dev        = (period_new >= HPERIOD) ?
                      period_new - HPERIOD :
                      HPERIOD - period_new;
  assign good       = dev <= {5'd0, TOL};
  assign period     = period_q;
  assign sync_len   = slen_q;

  // Next-state for the sampler and both measurement counters.
  always_comb begin
    hs_d     = hs_q;
    per_d    = per_q;
    period_d = period_q;
    len_d    = len_q;
    slen_d   = slen_q;
    if (cend) begin
      hs_d = hsync_in;
      if (edge_det) begin
        per_d    = '0;
        period_d = period_new;
      end else if (!timeout) begin
        per_d = per_q + 9'd1;
      end
      if (fall) begin
        slen_d = len_q;
        len_d  = '0;
      end else if (hsync_in && !(&len_q)) begin
        len_d = len_q + 6'd1;
      end
    end
  end

  // Measurement state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q     <= 1'b0;
      per_q    <= '0;
      period_q <= '0;
      len_q    <= '0;
      slen_q   <= '0;
    end else begin
      hs_q     <= hs_d;
      per_q    <= per_d;
      period_q <= period_d;
      len_q    <= len_d;
      slen_q   <= slen_d;
    end
  end

endmodule

// File: rtl/video_hsync_lock.sv
// Hsync lock FSM and recovered horizontal flywheel counter.
// Follows an external sync once a stable line period is seen.
module video_hsync_lock
  import video_timing_pkg::*;
#(
  parameter logic [8:0] HPERIOD        = 9'd448,
  parameter logic [8:0] EDGE_HCOUNT    = 9'd11,
  parameter logic [8:0] LINE_START_POS = 9'd88,
  parameter logic [3:0] TOL            = 4'd2,
  parameter logic [2:0] LOCK_LINES     = 3'd4,
  parameter logic [2:0] MISS_MAX       = 3'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cend,
  input  logic       hsync_in,
  output logic       locked,
  output logic [8:0] hcount_rec,
  output logic       line_start_rec,
  output logic [8:0] period,
  output logic [5:0] sync_len,
  output logic       err
);

  hs_state_e  state_q, state_d;
  logic [8:0] hcnt_q, hcnt_d;
  logic [8:0] nxt;
  logic [2:0] good_q, good_d;
  logic [2:0] miss_q, miss_d;
  logic       acc_q, acc_d;
  logic       err_q, err_d;
  logic       ls_q, ls_d;
  logic       locked_q, locked_d;
  logic       acc_now;
  logic       win;
  logic       close;

  logic       edge_det;
  logic [8:0] period_new;
  logic       good;
  logic       timeout;

  video_hsync_meas #(
    .HPERIOD (HPERIOD),
    .TOL     (TOL)
  ) u_meas (
    .clk        (clk),
    .rst        (rst),
    .cend       (cend),
    .hsync_in   (hsync_in),
    .edge_det   (edge_det),
    .period_new (period_new),
    .good       (good),
    .timeout    (timeout),
    .period     (period),
    .sync_len   (sync_len)
  );

  assign nxt   = (hcnt_q == HPERIOD - 9'd1) ? '0 : hcnt_q + 9'd1;
  assign win   = hdist(nxt, EDGE_HCOUNT, HPERIOD) <= {5'd0, TOL};
  assign close = nxt == EDGE_HCOUNT + {5'd0, TOL} + 9'd1;

  assign locked         = locked_q;
  assign hcount_rec     = hcnt_q;
  assign line_start_rec = ls_q;
  assign err            = err_q;

  // Lock FSM, flywheel phase and miss tracking.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    good_d  = good_q;
    miss_d  = miss_q;
    acc_d   = acc_q;
    err_d   = 1'b0;
    acc_now = 1'b0;
    if (cend) begin
      hcnt_d = nxt;
      unique case (state_q)
        SEARCH: begin
          if (edge_det) begin
            hcnt_d  = EDGE_HCOUNT;
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (edge_det) begin
            hcnt_d = EDGE_HCOUNT;
            if (good) begin
              good_d = good_q + 3'd1;
              if (good_q + 3'd1 == LOCK_LINES) begin
                state_d = LOCKED;
                miss_d  = '0;
                acc_d   = 1'b1;
              end
            end else begin
              err_d  = 1'b1;
              good_d = '0;
            end
          end else if (timeout) begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          acc_now = edge_det & win;
          if (acc_now) begin
            hcnt_d = EDGE_HCOUNT;
            miss_d = '0;
            acc_d  = 1'b1;
          end else if (edge_det) begin
            err_d = 1'b1;
          end
          if (!acc_now && close) begin
            acc_d = 1'b0;
            if (!acc_q) begin
              err_d  = 1'b1;
              miss_d = miss_q + 3'd1;
              if (miss_q + 3'd1 == MISS_MAX) begin
                state_d = SEARCH;
              end
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    ls_d     = cend && (state_q == LOCKED) &&
               (hcnt_d == LINE_START_POS);
    locked_d = state_d == LOCKED;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      hcnt_q   <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      acc_q    <= 1'b0;
      err_q    <= 1'b0;
      ls_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      ls_q     <= ls_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: tb/tb_video_hsync_lock.sv
// Testbench for video_hsync_lock: timeline model of the sync
// receiver compared every clk, plus hand-computed checkpoints.
module tb_video_hsync_lock;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cend = 1'b0;
  logic       hsync_in = 1'b0;
  logic       locked;
  logic [8:0] hcount_rec;
  logic       line_start_rec;
  logic [8:0] period;
  logic [5:0] sync_len;
  logic       err;

  video_hsync_lock dut (
    .clk            (clk),
    .rst            (rst),
    .cend           (cend),
    .hsync_in       (hsync_in),
    .locked         (locked),
    .hcount_rec     (hcount_rec),
    .line_start_rec (line_start_rec),
    .period         (period),
    .sync_len       (sync_len),
    .err            (err)
  );

  always #5 clk = ~clk;

  localparam int LP  = 448;
  localparam int EH  = 11;
  localparam int TL  = 2;
  localparam int LKN = 4;
  localparam int MSX = 3;

  int n_vec = 0;
  int n_bad = 0;
  int n_err = 0;
  int err_hc = -1;

  // model: everything expressed against an absolute cend timeline
  int t, last_rise, anc_t, anc_v;
  int mode, goods, misses;
  bit acc, hs_prev;
  int e_period, e_slen, e_hc;
  bit e_locked, e_err, e_ls;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    t = 0; last_rise = -1; anc_t = -1; anc_v = 0;
    mode = 0; goods = 0; misses = 0; acc = 0; hs_prev = 0;
    e_period = 0; e_slen = 0; e_hc = 0;
    e_locked = 0; e_err = 0; e_ls = 0;
  endtask

  task automatic m_cend(input bit hs);
    bit rise, fall, tmo, good, acc_now, reph;
    int pc, pn, nat, e, dv, old_mode;
    rise = hs && !hs_prev;
    fall = !hs && hs_prev;
    pc = t - last_rise - 1;
    if (pc > 511) pc = 511;
    pn = (pc + 1 > 511) ? 511 : pc + 1;
    tmo = pc == 511;
    dv = pn - LP;
    if (dv < 0) dv = -dv;
    good = dv <= TL;
    nat = (anc_v + t - anc_t) % LP;
    old_mode = mode;
    e_err = 0;
    reph = 0;
    if (fall) e_slen = (t - last_rise > 63) ? 63 : t - last_rise;
    if (rise) e_period = pn;
    case (mode)
      0: if (rise) begin
        reph = 1; mode = 1; goods = 0;
      end
      1: begin
        if (rise) begin
          reph = 1;
          if (good) begin
            goods++;
            if (goods == LKN) begin
              mode = 2; misses = 0; acc = 1;
            end
          end else begin
            e_err = 1; goods = 0;
          end
        end else if (tmo) mode = 0;
      end
      default: begin
        e = nat - EH;
        if (e > LP / 2 - 1) e -= LP;
        if (e < 0) e = -e;
        acc_now = rise && e <= TL;
        if (acc_now) begin
          reph = 1; misses = 0; acc = 1;
        end else if (rise) e_err = 1;
        if (!acc_now && nat == EH + TL + 1) begin
          if (!acc) begin
            e_err = 1;
            misses++;
            if (misses == MSX) mode = 0;
          end
          acc = 0;
        end
      end
    endcase
    if (reph) begin
      anc_t = t; anc_v = EH;
    end
    e_hc = reph ? EH : nat;
    e_ls = (old_mode == 2) && (e_hc == 88);
    e_locked = mode == 2;
    if (rise) last_rise = t;
    hs_prev = hs;
    t++;
  endtask

  // compare process: every clk, away from the active edge
  always @(posedge clk) begin
    #2;
    chk("locked", locked, e_locked);
    chk("hcount_rec", hcount_rec, e_hc);
    chk("line_start_rec", line_start_rec, e_ls);
    chk("period", period, e_period);
    chk("sync_len", sync_len, e_slen);
    chk("err", err, e_err);
  end

  task automatic step(input logic hs, input logic ce);
    @(negedge clk);
    hsync_in = hs;
    cend = ce;
    if (ce) m_cend(hs);
    else begin
      e_err = 0; e_ls = 0;
    end
    @(posedge clk);
    #1;
    if (err) begin
      n_err++; err_hc = hcount_rec;
    end
  endtask

  task automatic do_line(input int len, input bit on,
                         input int gap_at, input int gap_len);
    logic h;
    for (int c = 0; c < len; c++) begin
      h = on && c >= 10 && c < 43;
      if (c == gap_at)
        for (int g = 0; g < gap_len; g++)
          step(logic'($urandom_range(0, 1)), 1'b0);
      step(h, 1'b1);
      step(h, 1'b0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " locked"}, locked, 0);
    chk({tag, " hcount"}, hcount_rec, 0);
    chk({tag, " line_start"}, line_start_rec, 0);
    chk({tag, " period"}, period, 0);
    chk({tag, " sync_len"}, sync_len, 0);
    chk({tag, " err"}, err, 0);
  endtask

  int vlen[7] = '{448, 500, 448, 448, 448, 448, 448};
  int verr[7] = '{0, 0, 1, 0, 0, 0, 0};

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // ideal generator from reset
    for (int k = 1; k <= 6; k++) begin
      do_line(448, 1'b1, -1, 0);
      if (k == 4) chk("lock after 4 lines", locked, 0);
      if (k == 5) chk("lock after 5 lines", locked, 1);
    end
    chk("ideal period", period, 448);
    chk("ideal sync_len", sync_len, 33);
    chk("ideal hcount at line end", hcount_rec, 0);

    // period 450 accepted, then 452 misses
    n_err = 0;
    do_line(450, 1'b1, -1, 0);
    chk("errs line 450", n_err, 0);
    n_err = 0;
    do_line(452, 1'b1, -1, 0);
    chk("errs edge at 450", n_err, 0);
    chk("period 450", period, 450);
    n_err = 0;
    do_line(444, 1'b1, -1, 0);
    chk("errs edge at 452", n_err, 2);
    chk("period 452", period, 452);
    chk("locked after one miss", locked, 1);
    n_err = 0;
    do_line(448, 1'b1, -1, 0);
    do_line(448, 1'b1, -1, 0);
    chk("errs after realign", n_err, 0);
    chk("locked after realign", locked, 1);

    // hsync lost
    for (int k = 1; k <= 3; k++) begin
      n_err = 0;
      err_hc = -1;
      do_line(448, 1'b0, -1, 0);
      chk("errs per lost line", n_err, 1);
      chk("err hcount", err_hc, 14);
      chk("locked while lost", locked, k < 3);
    end
    do_line(448, 1'b0, -1, 0);
    do_line(448, 1'b1, -1, 0);
    chk("period after timeout", period, 511);
    chk("search after timeout", locked, 0);

    // verify with one bad period in the middle
    for (int i = 0; i < 7; i++) begin
      n_err = 0;
      do_line(vlen[i], 1'b1, -1, 0);
      chk("verify errs", n_err, verr[i]);
      if (i == 5) chk("verify not yet locked", locked, 0);
      if (i == 6) chk("verify locked", locked, 1);
    end

    // reset mid-line while locked
    do_line(200, 1'b1, -1, 0);
    chk("locked before rst", locked, 1);
    @(posedge clk);
    #3;
    cend = 1'b0;
    rst = 1'b1;
    m_reset();
    #1;
    chk_zero("async rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      do_line(448, 1'b1, -1, 0);
      if (k == 4) chk("relock after 4", locked, 0);
      if (k == 5) chk("relock after 5", locked, 1);
    end

    // cend gated off mid-line
    n_err = 0;
    do_line(448, 1'b1, 200, 100);
    do_line(448, 1'b1, -1, 0);
    chk("errs around gap", n_err, 0);
    chk("locked after gap", locked, 1);
    chk("hcount after gap", hcount_rec, 0);
    chk("period after gap", period, 448);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
